vm3_mmu_xlat: RTL and testbench

- Virtual-to-physical address translation stage for the VM3 memory management unit.
- Consumes the 32x16 PAR/PDR dual-port register RAM (vm3_mmu): port A holds the page address register (PAR), port B holds the page descriptor register (PDR).
- Takes a 16-bit CPU virtual address, reads the PAR and PDR for that page in one RAM cycle, and returns an 18- or 22-bit physical address or an abort.
- Keeps the abort status fields of SR0.

---
 rtl/vm3_mmu_pkg.sv | 23 ++
 rtl/vm3_mmu_chk.sv | 24 ++
 rtl/vm3_mmu_xlat.sv | 95 +++++++++
 tb/tb_vm3_mmu_xlat.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vm3_mmu_pkg.sv
// vm3_mmu_pkg: shared ACF codes, SR0 layout, RAM address layout and FSM encoding for the VM3 MMU
package vm3_mmu_pkg;
    localparam logic [1:0] ACF_NR = 2'b00;
    localparam logic [1:0] ACF_RO = 2'b01;
    localparam logic [1:0] ACF_RW = 2'b11;
    localparam int SR0_NR   = 15;
    localparam int SR0_LEN  = 14;
    localparam int SR0_RO   = 13;
    localparam int SR0_MODE = 5;
    localparam int SR0_PAGE = 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOOK = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [5:0] IO_PAGE = 6'b111111;
    typedef struct packed {
        logic       user;
        logic       pdr_sel;
        logic [2:0] page;
    } ram_addr_t;
    function automatic ram_addr_t ram_addr(input logic user, input logic pdr_sel, input logic [2:0] page);
        return '{user: user, pdr_sel: pdr_sel, page: page};
    endfunction
endpackage

// File: rtl/vm3_mmu_chk.sv
// vm3_mmu_chk: priority-encoded PDR access check giving {non-resident, length, read-only}
module vm3_mmu_chk
    import vm3_mmu_pkg::*;
#(
    parameter bit NONE_RO_WR = 1'b1
) (
    input  logic [15:0] pdr_i,
    input  logic [6:0]  blk_i,
    input  logic        wr_i,
    output logic [2:0]  flags_o
);
    logic [1:0] acf;
    logic [6:0] plf;
    logic       nr;
    logic       len;
    logic       ro;
    assign acf = pdr_i[2:1];
    assign plf = pdr_i[14:8];
    assign nr  = acf == ACF_NR || acf == 2'b10;
    // ED selects an upward-growing (blk>PLF) or downward-growing (blk<PLF) page
    assign len = !nr && (pdr_i[3] ? blk_i < plf : blk_i > plf);
    assign ro  = !nr && !len && acf == ACF_RO && wr_i && NONE_RO_WR;
    assign flags_o = {nr, len, ro};
endmodule

// File: rtl/vm3_mmu_xlat.sv
// vm3_mmu_xlat: three-state virtual-to-physical translation using the PAR/PDR RAM, with SR0 abort capture
module vm3_mmu_xlat
    import vm3_mmu_pkg::*;
#(
    parameter bit NONE_RO_WR = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic [15:0] vaddr_i,
    input  logic        user_i,
    input  logic        wr_i,
    input  logic        ena_i,
    input  logic        m22_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [21:0] paddr_o,
    output logic        abort_o,
    output logic [15:0] sr0_o,
    input  logic        sr0_clr_i,
    output logic [4:0]  ram_addr_a_o,
    output logic [4:0]  ram_addr_b_o,
    input  logic [15:0] ram_q_a_i,
    input  logic [15:0] ram_q_b_i
);
    logic [1:0]  state_q, state_d;
    logic [15:0] vaddr_q;
    logic        user_q, wr_q, ena_q, m22_q;
    logic [21:0] paddr_q, paddr_d;
    logic        abort_q, abort_d;
    logic [15:0] sr0_q, sr0_d;
    logic        idle, look, usr, abt;
    logic [2:0]  page;
    logic [2:0]  flags;
    logic [15:0] paf;
    logic [21:0] sum, xlat, byp;

    assign idle = state_q == ST_IDLE;
    assign look = state_q == ST_LOOK;
    // While idle the RAM address follows the live request so data is ready in LOOK
    assign page = idle ? vaddr_i[15:13] : vaddr_q[15:13];
    assign usr  = idle ? user_i : user_q;
    assign ram_addr_a_o = ram_addr(usr, 1'b0, page);
    assign ram_addr_b_o = ram_addr(usr, 1'b1, page);

    vm3_mmu_chk #(.NONE_RO_WR(NONE_RO_WR)) u_chk (
        .pdr_i   (ram_q_b_i),
        .blk_i   (vaddr_q[12:6]),
        .wr_i    (wr_q),
        .flags_o (flags)
    );

    assign paf  = m22_q ? ram_q_a_i : {4'b0, ram_q_a_i[11:0]};
    assign sum  = {paf, 6'b0} + {9'b0, vaddr_q[12:0]};
    assign xlat = m22_q ? sum : {4'b0, sum[17:0]};
    assign byp  = &vaddr_q[15:13] ? {IO_PAGE, vaddr_q} : {6'b0, vaddr_q};
    assign abt  = ena_q && |flags;

    always_comb begin
        state_d = idle ? (req_i ? ST_LOOK : ST_IDLE) : look ? ST_DONE : ST_IDLE;
        paddr_d = look ? (ena_q ? xlat : byp) : paddr_q;
        abort_d = look ? abt : abort_q;
        // A fresh abort beats a same-edge clear; otherwise SR0 stays frozen while a flag is set
        sr0_d   = (look && abt && (sr0_q[SR0_NR:SR0_RO] == 3'b0 || sr0_clr_i))
                  ? {flags, 6'b0, user_q, user_q, 1'b0, vaddr_q[15:13], 1'b0}
                  : sr0_clr_i ? {3'b0, sr0_q[12:0]} : sr0_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            paddr_q <= '0;
            abort_q <= 1'b0;
            sr0_q   <= '0;
        end else begin
            state_q <= state_d;
            paddr_q <= paddr_d;
            abort_q <= abort_d;
            sr0_q   <= sr0_d;
        end
        if (idle && req_i) begin
            vaddr_q <= vaddr_i;
            user_q  <= user_i;
            wr_q    <= wr_i;
            ena_q   <= ena_i;
            m22_q   <= m22_i;
        end
    end

    assign ready_o = idle;
    assign done_o  = state_q == ST_DONE;
    assign paddr_o = paddr_q;
    assign abort_o = abort_q;
    assign sr0_o   = sr0_q;
endmodule

// File: tb/tb_vm3_mmu_xlat.sv
// tb_vm3_mmu_xlat: directed scoreboard bench for vm3_mmu_xlat with a behavioural PAR/PDR RAM
module tb_vm3_mmu_xlat;
    logic        clk = 1'b0;
    logic        reset, req, user, wr, ena, m22, sr0_clr;
    logic [15:0] vaddr;
    logic        ready, done, abort;
    logic [21:0] paddr;
    logic [15:0] sr0;
    logic [4:0]  addr_a, addr_b;
    logic [15:0] q_a, q_b;
    logic [15:0] mem [32];

    typedef struct packed {
        logic [21:0] p;
        logic        a;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    vm3_mmu_xlat #(.NONE_RO_WR(1'b1)) dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .req_i        (req),
        .vaddr_i      (vaddr),
        .user_i       (user),
        .wr_i         (wr),
        .ena_i        (ena),
        .m22_i        (m22),
        .ready_o      (ready),
        .done_o       (done),
        .paddr_o      (paddr),
        .abort_o      (abort),
        .sr0_o        (sr0),
        .sr0_clr_i    (sr0_clr),
        .ram_addr_a_o (addr_a),
        .ram_addr_b_o (addr_b),
        .ram_q_a_i    (q_a),
        .ram_q_b_i    (q_b)
    );

    always @(posedge clk) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("paddr", 32'(paddr), 32'(e.p));
                chk("abort", 32'(abort), 32'(e.a));
            end
        end
    end

    task automatic xlat(input logic [15:0] va, input logic u, input logic w, input logic e,
                        input logic m, input logic [21:0] ep, input logic ea,
                        input bit hold, input bit clr);
        int lat;
        @(negedge clk);
        chk("ready_pre", 32'(ready), 32'd1);
        vaddr = va; user = u; wr = w; ena = e; m22 = m; req = 1'b1;
        exp_q.push_back('{p: ep, a: ea});
        @(posedge clk);
        #1;
        vaddr = ~va; user = ~u; wr = ~w; ena = ~e; m22 = ~m;
        if (!hold) req = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("busy", 32'(ready), 32'd0);
                sr0_clr = clr;
            end
            if (i == 2) begin
                sr0_clr = 1'b0;
                req = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd2);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; vaddr = '0; user = 1'b0; wr = 1'b0;
        ena = 1'b0; m22 = 1'b0; sr0_clr = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_sr0", 32'(sr0), 32'd0);

        mem[1] = 16'h0200; mem[9] = 16'h7F06;
        xlat(16'h2010, 0, 0, 1, 1, 22'h008010, 0, 0, 0);
        mem[1] = 16'hF200;
        xlat(16'h2010, 0, 0, 1, 0, 22'h008010, 0, 0, 0);
        xlat(16'h2010, 0, 0, 1, 1, 22'h3C8010, 0, 0, 0);

        mem[9] = 16'h0206;
        xlat(16'h2080, 0, 0, 1, 1, 22'h3C8080, 0, 0, 0);
        chk("sr0_blk_eq_plf", 32'(sr0), 32'h0);
        xlat(16'h2100, 0, 0, 1, 1, 22'h3C8100, 1, 0, 0);
        chk("sr0_len", 32'(sr0), 32'h4002);
        mem[3] = 16'h0000; mem[11] = 16'h0000;
        xlat(16'h6000, 0, 0, 1, 1, 22'h000000, 1, 0, 0);
        chk("sr0_frozen", 32'(sr0), 32'h4002);
        @(negedge clk);
        sr0_clr = 1'b1;
        @(posedge clk);
        #1 sr0_clr = 1'b0;
        @(negedge clk);
        chk("sr0_clr", 32'(sr0), 32'h0002);

        mem[21] = 16'h0100; mem[29] = 16'h7F02;
        xlat(16'hA000, 1, 1, 1, 1, 22'h004000, 1, 0, 0);
        chk("sr0_ro", 32'(sr0), 32'h206A);
        xlat(16'hA000, 1, 0, 1, 1, 22'h004000, 0, 0, 0);
        mem[29] = 16'h7F0A;
        xlat(16'hA000, 1, 0, 1, 1, 22'h004000, 1, 0, 0);
        chk("sr0_ed_frozen", 32'(sr0), 32'h206A);

        xlat(16'hE000, 0, 1, 0, 1, 22'h3FE000, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk("no_requeue_ready", 32'(ready), 32'd1);
        xlat(16'h1234, 1, 1, 0, 0, 22'h001234, 0, 0, 0);

        xlat(16'h2100, 0, 0, 1, 1, 22'h3C8100, 1, 0, 1);
        chk("sr0_clr_vs_abort", 32'(sr0), 32'h4002);

        @(negedge clk);
        vaddr = 16'h2010; user = 1'b0; wr = 1'b0; ena = 1'b1; m22 = 1'b1; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_sr0", 32'(sr0), 32'd0);
        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
